// File: rtl/uart_pkg.sv
// Shared definitions for the UART channel multiplexer: header field layout,
// channel limit and the TX/RX state encodings.
package uart_pkg;

  // Header byte layout: {ch[1:0], len_m1[5:0]}
  localparam int CH_MSB       = 7;
  localparam int CH_LSB       = 6;
  localparam int LEN_MSB      = 5;
  localparam int CH_W         = CH_MSB - CH_LSB + 1;
  localparam int LEN_W        = LEN_MSB + 1;
  localparam int MAX_CHANNELS = 4;

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_HEAD = 2'd1,
    T_BODY = 2'd2
  } tx_state_t;

  typedef enum logic [1:0] {
    R_HEAD = 2'd0,
    R_BODY = 2'd1,
    R_DROP = 2'd2
  } rx_state_t;

  // Builds the one-byte frame header from a channel index and length-minus-one.
  function automatic logic [7:0] make_header(input logic [CH_W-1:0]  ch,
                                             input logic [LEN_W-1:0] len_m1);
    return {ch, len_m1};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search for the next grant starts one position
// after the requester that was granted last. The last-granted position is
// kept one-hot so the block works for any N >= 1.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  // After reset the last grant points at the highest index, so index 0 wins first.
  localparam logic [N-1:0] LAST_INIT = N'(1) << (N - 1);

  logic [N-1:0] last_q;
  int           last_idx;
  logic         found;

  // Combinational one-hot grant: first requester after last_idx, wrapping.
  always_comb begin
    last_idx = 0;
    for (int i = 0; i < N; i++) begin
      if (last_q[i]) last_idx = i;
    end
    grant = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] && (i == ((last_idx + k) % N))) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

  // Remember the winner when the consumer accepts the grant.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_q <= LAST_INIT;
    end else if (advance && (|req)) begin
      last_q <= grant;
    end
  end

endmodule

// File: rtl/uart_channel_mux.sv
// Packet multiplexer between up to four channel clients and a single
// uart_comm byte link. TX arbitrates whole packets round-robin and frames
// each with a {ch, len_m1} header; RX parses the same framing and routes
// payload bytes to the addressed channel. TX and RX are fully independent.
//
// Handshakes: send_flag is a write strobe, asserted only in cycles where
// sendable is high; recv_flag is a pop strobe, asserted only in cycles where
// receivable is high (at most one pop per cycle); tx_pop[i] marks the cycle
// in which tx_data[i] was consumed; rx_valid[i] is a one-cycle pulse with no
// backpressure, qualified by rx_last on the final byte of a packet.
module uart_channel_mux
  import uart_pkg::*;
#(
  parameter int CHANNELS = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  // channel TX clients
  input  logic [CHANNELS-1:0]   tx_req,
  input  logic [6*CHANNELS-1:0] tx_len,
  input  logic [8*CHANNELS-1:0] tx_data,
  output logic [CHANNELS-1:0]   tx_grant,
  output logic [CHANNELS-1:0]   tx_pop,
  // uart_comm send side
  output logic                  send_flag,
  output logic [7:0]            send_data,
  input  logic                  sendable,
  // uart_comm receive side
  output logic                  recv_flag,
  input  logic [7:0]            recv_data,
  input  logic                  receivable,
  // channel RX sinks
  output logic [CHANNELS-1:0]   rx_valid,
  output logic [7:0]            rx_data,
  output logic                  rx_last,
  output logic [7:0]            rx_drop_cnt,
  // state visibility
  output tx_state_t             tx_state,
  output rx_state_t             rx_state
);

  // ---------------------------------------------------------------- TX side
  tx_state_t             tx_state_n;
  logic [CHANNELS-1:0]   arb_grant;
  logic                  arb_advance;
  logic [CH_W-1:0]       sel_ch;
  logic [LEN_W-1:0]      sel_len;
  logic [7:0]            cur_data;
  logic [CH_W-1:0]       tx_ch;
  logic [LEN_W-1:0]      tx_len_q;
  logic [LEN_W-1:0]      tx_cnt;

  rr_arbiter #(.N(CHANNELS)) u_arb (
    .CLK     (CLK),
    .RST     (RST),
    .req     (tx_req),
    .advance (arb_advance),
    .grant   (arb_grant)
  );

  // Decode the arbiter winner into an index and its length, and pick the
  // payload head of the channel currently holding the grant.
  always_comb begin
    sel_ch   = '0;
    sel_len  = '0;
    cur_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (arb_grant[i]) begin
        sel_ch  = CH_W'(i);
        sel_len = tx_len[6*i +: 6];
      end
      if (tx_grant[i]) begin
        cur_data = tx_data[8*i +: 8];
      end
    end
  end

  // TX state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) tx_state <= T_IDLE;
    else     tx_state <= tx_state_n;
  end

  // TX next state and write strobes; nothing is written while sendable is low.
  always_comb begin
    tx_state_n  = tx_state;
    send_flag   = 1'b0;
    send_data   = 8'h00;
    tx_pop      = '0;
    arb_advance = 1'b0;
    case (tx_state)
      T_IDLE: begin
        if (|tx_req) begin
          arb_advance = 1'b1;
          tx_state_n  = T_HEAD;
        end
      end
      T_HEAD: begin
        if (sendable) begin
          send_flag  = 1'b1;
          send_data  = make_header(tx_ch, tx_len_q);
          tx_state_n = T_BODY;
        end
      end
      T_BODY: begin
        if (sendable) begin
          send_flag = 1'b1;
          send_data = cur_data;
          tx_pop    = tx_grant;
          if (tx_cnt == '0) tx_state_n = T_IDLE;
        end
      end
      default: tx_state_n = T_IDLE;
    endcase
  end

  // TX datapath: latch the winner in T_IDLE, count payload bytes in T_BODY,
  // and drop the grant together with the final byte.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_grant <= '0;
      tx_ch    <= '0;
      tx_len_q <= '0;
      tx_cnt   <= '0;
    end else begin
      case (tx_state)
        T_IDLE: begin
          if (|tx_req) begin
            tx_grant <= arb_grant;
            tx_ch    <= sel_ch;
            tx_len_q <= sel_len;
          end
        end
        T_HEAD: begin
          if (sendable) tx_cnt <= tx_len_q;
        end
        T_BODY: begin
          if (sendable) begin
            tx_cnt <= tx_cnt - 6'd1;
            if (tx_cnt == '0) tx_grant <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX side
  rx_state_t           rx_state_n;
  logic [CH_W-1:0]     rx_ch;
  logic [LEN_W-1:0]    rx_cnt;
  logic                hdr_ok;
  logic [CHANNELS-1:0] rx_sel;

  // Header channel check and one-hot decode of the latched channel.
  always_comb begin
    hdr_ok = ({1'b0, recv_data[CH_MSB:CH_LSB]} < 3'(CHANNELS));
    rx_sel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      rx_sel[i] = (rx_ch == CH_W'(i));
    end
  end

  // RX state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) rx_state <= R_HEAD;
    else     rx_state <= rx_state_n;
  end

  // RX next state and pop strobe; the pop is held low during reset so a
  // non-empty FIFO is not drained while the block is being cleared.
  always_comb begin
    rx_state_n = rx_state;
    recv_flag  = 1'b0;
    case (rx_state)
      R_HEAD: begin
        if (receivable) begin
          recv_flag  = 1'b1;
          rx_state_n = hdr_ok ? R_BODY : R_DROP;
        end
      end
      R_BODY, R_DROP: begin
        if (receivable) begin
          recv_flag = 1'b1;
          if (rx_cnt == '0) rx_state_n = R_HEAD;
        end
      end
      default: rx_state_n = R_HEAD;
    endcase
    if (RST) recv_flag = 1'b0;
  end

  // RX datapath: latch the header, forward payload one cycle after the pop,
  // and count discarded packets with saturation.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_ch       <= '0;
      rx_cnt      <= '0;
      rx_valid    <= '0;
      rx_data     <= 8'h00;
      rx_last     <= 1'b0;
      rx_drop_cnt <= 8'h00;
    end else begin
      rx_valid <= '0;
      rx_last  <= 1'b0;
      case (rx_state)
        R_HEAD: begin
          if (receivable) begin
            rx_ch  <= recv_data[CH_MSB:CH_LSB];
            rx_cnt <= recv_data[LEN_MSB:0];
            if (!hdr_ok && (rx_drop_cnt != 8'hFF)) rx_drop_cnt <= rx_drop_cnt + 8'd1;
          end
        end
        R_BODY: begin
          if (receivable) begin
            rx_valid <= rx_sel;
            rx_data  <= recv_data;
            rx_last  <= (rx_cnt == '0);
            rx_cnt   <= rx_cnt - 6'd1;
          end
        end
        R_DROP: begin
          if (receivable) rx_cnt <= rx_cnt - 6'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/uart_channel_mux.md
# uart_channel_mux

Packet-level multiplexer that shares the single `uart_comm` byte link between up to four on-chip channels, for example the CPU console and the program loader.

- **TX:** round-robin arbitrates whole packets from the requesting channels. Each packet is framed with a one-byte header and pushed into the `uart_comm` send FIFO.
- **RX:** parses the same framing from the `uart_comm` receive FIFO and routes payload bytes to the addressed channel.
- **Placement:** sits directly between the channel clients and `uart_comm`.

## Interface
- `CHANNELS`, default 2 — number of channels, legal 1..4.
- `CLK`  in  1  clock.
- `RST`  in  1  reset, asynchronous, active-high.
- `tx_req`  in  CHANNELS  channel i holds high while it has a packet pending.
- `tx_len`  in  6*CHANNELS  packet length minus 1 (1..64 bytes); stable while `tx_req[i]` is high.
- `tx_data`  in  8*CHANNELS  current payload byte (FIFO-head style); valid whenever `tx_req[i]` is high.
- `tx_grant`  out  CHANNELS  one-hot; high for the whole packet of the selected channel.
- `tx_pop`  out  CHANNELS  one-cycle pulse; the byte on `tx_data[i]` was consumed this cycle.
- `send_flag`  out  1  write strobe to `uart_comm`.
- `send_data`  out  8  write byte to `uart_comm`.
- `sendable`  in  1  `uart_comm` send FIFO not full.
- `recv_flag`  out  1  pop strobe to `uart_comm`.
- `recv_data`  in  8  receive FIFO head; valid while `receivable` is high.
- `receivable`  in  1  `uart_comm` receive FIFO not empty.
- `rx_valid`  out  CHANNELS  one-cycle pulse, payload byte for channel i.
- `rx_data`  out  8  payload byte, shared by all channels.
- `rx_last`  out  1  qualifies `rx_valid`; high on the final byte of a packet.
- `rx_drop_cnt`  out  8  saturating count of packets discarded for a bad channel index.

## Operation
- **Header byte:** `{ch[1:0], len_m1[5:0]}`, followed by `len_m1+1` payload bytes. There is no escape and no checksum; the `uart_comm` parity is the only check.
- **TX FSM states:**
  - T_IDLE: if any `tx_req` is high, grant using round-robin. The search starts at the channel after the last granted one; after reset the last granted channel is CHANNELS-1. Latch `len_m1` and go to T_HEAD.
  - T_HEAD: when `sendable`, drive `send_flag=1` with the header byte, load the byte counter, go to T_BODY.
  - T_BODY: when `sendable`, drive `send_flag=1` with `send_data=tx_data[g]` and `tx_pop[g]=1`. On the byte with counter==0, clear `tx_grant` and return to T_IDLE.
- **TX rules:**
  - Dropping `tx_req[g]` mid-packet is illegal; the FSM ignores `tx_req` after the grant.
  - No write is issued in any cycle where `sendable` is 0.
- **RX FSM states:**
  - R_HEAD: when `receivable`, pop the byte (`recv_flag=1`) and latch ch and len_m1. If `ch < CHANNELS`, go to R_BODY; otherwise go to R_DROP and increment `rx_drop_cnt`, which saturates at 255.
  - R_BODY: for each cycle with `receivable`, pop the byte and forward it. Return to R_HEAD after len_m1+1 bytes.
  - R_DROP: same popping and counting as R_BODY, but nothing is forwarded.
- **RX rules:**
  - Channel sinks have no backpressure; they accept one byte per cycle.
  - The receive FIFO is popped at most once per cycle.
- **Independence:** the TX and RX FSMs share nothing and may be active in the same cycle.

## Timing
- **Reset values:** every output is 0, both FSMs are idle, and the round-robin pointer is CHANNELS-1. RST mid-packet aborts immediately; a partial frame already handed to `uart_comm` is not recovered.
- **Combinational outputs:** `send_flag`, `send_data`, `tx_pop`, `recv_flag`.
- **Registered outputs:** `tx_grant`, `rx_valid`, `rx_data`, `rx_last`, `rx_drop_cnt`.
- **TX latency:** `tx_req` rising in cycle n gives `tx_grant` in n+1. With `sendable` held high, the header is written in n+1, payload byte k is written in n+2+k, and T_IDLE is reached the cycle after the last byte.
- **Back-to-back packets:** a minimum of one idle cycle between packets, spent in T_IDLE.
- **RX latency:** a byte popped in cycle n appears as `rx_valid`/`rx_data` in n+1.
- **len_m1=0:** a single-byte packet; `rx_last` is set on that byte.

## Structure
- **Shared package `uart_pkg`:** header field positions (CH_MSB=7, CH_LSB=6, LEN_MSB=5), MAX_CHANNELS=4, and the TX/RX state encodings.
- **Sub-module `rr_arbiter`:** #(N); inputs req, advance; output one-hot grant. It is reusable for other shared resources in the design.

## Test plan
- **Single TX packet:** ch1 requests len_m1=2 with data A0,A1,A2; `sendable`=1 → `send_data` sequence 0x42,A0,A1,A2 and three `tx_pop[1]` pulses.
- **Contention:** ch0 and ch1 request in the same cycle after reset → ch0 is served first, then ch1, with the ch1 header written one cycle after the last ch0 byte plus the T_IDLE cycle.
- **Backpressure:** toggle `sendable` 1010… mid-packet → no `send_flag` while `sendable`=0 and the byte order is preserved.
- **RX routing:** feed 0x41,0x55,0x66 → `rx_valid[1]` twice with data 55,66; `rx_last` is set on 66.
- **Bad channel:** with CHANNELS=2, feed 0xC1,x,y → no `rx_valid`, `rx_drop_cnt`=1, and the next header is parsed correctly.
- **Reset mid-packet:** assert RST during T_BODY → all outputs return to 0 and the next request is served from T_IDLE with a fresh header.
